// File: rtl/maxnet_iter_ctrl.sv
// Control FSM for an iterative Maxnet competition over N neurons.
// Optional macro MAXNET_TIE_BREAK_EN: an all-zero step resolves to the lowest survivor of the previous step.
module maxnet_iter_ctrl #(
  parameter int N        = 4,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 8,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N-1:0]      nz,
  output logic              load_en,
  output logic              iter_en,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      winner_onehot,
  output logic [IDX_W-1:0]  winner_idx,
  output logic [ITER_W-1:0] iter_count,
  output logic              timeout,
  output logic              no_winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ITER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [N-1:0]      onehot_reg, onehot_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [ITER_W-1:0] iter_reg, iter_next;
  logic              timeout_reg, timeout_next;
  logic              no_winner_reg, no_winner_next;
  logic              nz_zero, nz_single;

`ifdef MAXNET_TIE_BREAK_EN
  logic [N-1:0]      prev_nz_reg, prev_nz_next;
`endif

  function automatic logic [IDX_W-1:0] low_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] low_bit(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  // Exactly one bit set iff clearing the lowest set bit leaves nothing.
  assign nz_zero   = (nz == '0);
  assign nz_single = !nz_zero && ((nz & (nz - N'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      onehot_reg    <= '0;
      idx_reg       <= '0;
      iter_reg      <= '0;
      timeout_reg   <= 1'b0;
      no_winner_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      onehot_reg    <= onehot_next;
      idx_reg       <= idx_next;
      iter_reg      <= iter_next;
      timeout_reg   <= timeout_next;
      no_winner_reg <= no_winner_next;
    end
  end

`ifdef MAXNET_TIE_BREAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_nz_reg <= '0;
    end else begin
      prev_nz_reg <= prev_nz_next;
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    onehot_next    = onehot_reg;
    idx_next       = idx_reg;
    iter_next      = iter_reg;
    timeout_next   = timeout_reg;
    no_winner_next = no_winner_reg;
`ifdef MAXNET_TIE_BREAK_EN
    prev_nz_next   = prev_nz_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next     = S_LOAD;
          onehot_next    = '0;
          idx_next       = '0;
          iter_next      = '0;
          timeout_next   = 1'b0;
          no_winner_next = 1'b0;
        end
      end
      S_LOAD: state_next = S_CHECK;
      S_CHECK: begin
        // Winner outranks budget exhaustion in the same CHECK.
        if (nz_single) begin
          state_next  = S_DONE;
          onehot_next = nz;
          idx_next    = low_idx(nz);
        end else if (nz_zero) begin
          state_next = S_DONE;
`ifdef MAXNET_TIE_BREAK_EN
          if (iter_reg != '0) begin
            onehot_next    = low_bit(prev_nz_reg);
            idx_next       = low_idx(prev_nz_reg);
            no_winner_next = 1'b0;
          end else begin
            no_winner_next = 1'b1;
          end
`else
          no_winner_next = 1'b1;
`endif
        end else if (iter_reg == ITER_W'(MAX_ITER)) begin
          state_next   = S_DONE;
          timeout_next = 1'b1;
        end else begin
          state_next = S_ITER;
`ifdef MAXNET_TIE_BREAK_EN
          prev_nz_next = nz;
`endif
        end
      end
      S_ITER: begin
        state_next = S_CHECK;
        if (iter_reg != '1) iter_next = iter_reg + ITER_W'(1);
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign load_en       = (state_reg == S_LOAD);
  assign iter_en       = (state_reg == S_ITER);
  assign busy          = (state_reg == S_LOAD) || (state_reg == S_CHECK) || (state_reg == S_ITER);
  assign done          = (state_reg == S_DONE);
  assign winner_onehot = onehot_reg;
  assign winner_idx    = idx_reg;
  assign iter_count    = iter_reg;
  assign timeout       = timeout_reg;
  assign no_winner     = no_winner_reg;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Bench for maxnet_iter_ctrl: per-run outcome model plus per-cycle output comparison.
// Honours MAXNET_TIE_BREAK_EN the same way as the design.
module tb_maxnet_iter_ctrl;
  localparam int N = 4;
  localparam int MAX_ITER = 3;
  localparam int ITER_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] nz = 4'b0;
  logic load_en, iter_en, busy, done, timeout, no_winner;
  logic [3:0] winner_onehot;
  logic [1:0] winner_idx;
  logic [7:0] iter_count;

  maxnet_iter_ctrl #(.N(N), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nz(nz),
    .load_en(load_en), .iter_en(iter_en), .busy(busy), .done(done),
    .winner_onehot(winner_onehot), .winner_idx(winner_idx),
    .iter_count(iter_count), .timeout(timeout), .no_winner(no_winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;
  bit e_load = 0, e_iter = 0, e_busy = 0, e_done = 0, e_to = 0, e_nw = 0;
  logic [3:0] e_oh = 0;
  logic [1:0] e_idx = 0;
  logic [7:0] e_cnt = 0;
  int iter_pulses = 0;
  int last_done_cyc = -1;
  int run_k = 0;
  int run_m = 0;
  logic [3:0] seq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("load_en", int'(load_en), int'(e_load));
      chk("iter_en", int'(iter_en), int'(e_iter));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("winner_onehot", int'(winner_onehot), int'(e_oh));
      chk("winner_idx", int'(winner_idx), int'(e_idx));
      chk("iter_count", int'(iter_count), int'(e_cnt));
      chk("timeout", int'(timeout), int'(e_to));
      chk("no_winner", int'(no_winner), int'(e_nw));
      if (iter_en) iter_pulses++;
      if (done) last_done_cyc = cyc;
    end
  end

  // Spec cycle numbering: the period after edge e is cycle e+1.
  function automatic int done_latency();
    return last_done_cyc + 1 - run_k;
  endfunction

  task automatic run(input bit poke, input string name);
    int j;
    bit fin;
    logic [3:0] v, prev, r_oh;
    logic [1:0] r_idx;
    bit r_to, r_nw;
    j = 0; fin = 0; prev = 0; r_oh = 0; r_idx = 0; r_to = 0; r_nw = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_k = cyc;
    iter_pulses = 0;
    e_load = 1; e_busy = 1; e_oh = 0; e_idx = 0; e_cnt = 0; e_to = 0; e_nw = 0;
    while (!fin) begin
      @(posedge clk); #1;
      start = 1'b0;
      v = seq[j];
      nz = v;
      e_load = 0; e_iter = 0; e_busy = 1; e_cnt = 8'(j);
      if ($countones(v) == 1) begin
        fin = 1;
        r_oh = v;
        for (int i = 3; i >= 0; i--) if (v[i]) r_idx = 2'(i);
      end else if (v == 4'b0) begin
        fin = 1;
`ifdef MAXNET_TIE_BREAK_EN
        if (j > 0) begin
          for (int i = 3; i >= 0; i--) if (prev[i]) r_idx = 2'(i);
          r_oh = 4'b1 << r_idx;
        end else begin
          r_nw = 1;
        end
`else
        r_nw = 1;
`endif
      end else if (j == MAX_ITER) begin
        fin = 1;
        r_to = 1;
      end else begin
        @(posedge clk); #1;
        nz = 4'($urandom);
        e_iter = 1; e_busy = 1;
        if (poke && j == 0) start = 1'b1;
        prev = v;
        j++;
      end
    end
    @(posedge clk); #1;
    nz = 4'($urandom);
    start = poke;
    e_busy = 0; e_done = 1; e_oh = r_oh; e_idx = r_idx; e_cnt = 8'(j); e_to = r_to; e_nw = r_nw;
    @(posedge clk); #1;
    start = 1'b0;
    e_done = 0;
    @(posedge clk); #1;
    run_m = j;
    $display("run %s: done_latency=%0d idx=%0d onehot=%b iter_count=%0d timeout=%0d no_winner=%0d",
             name, done_latency(), winner_idx, winner_onehot, iter_count, timeout, no_winner);
  endtask

  initial begin
    int saved_done;
    // Reset held with start toggling.
    cmp_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = ~start;
      nz = 4'($urandom);
    end
    chk("reset_busy", int'(busy), 0);
    chk("reset_iter_count", int'(iter_count), 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_load_en", int'(load_en), 0);
    $display("reset: outputs idle after release");

    seq = '{4'b0100};
    run(0, "immediate");
    chk("t2_latency", done_latency(), 3);
    chk("t2_idx", int'(winner_idx), 2);
    chk("t2_onehot", int'(winner_onehot), 4);
    chk("t2_count", int'(iter_count), 0);
    chk("t2_pulses", iter_pulses, 0);

    seq = '{4'b1111, 4'b1011, 4'b0010};
    run(0, "two_iter");
    chk("t3_latency", done_latency(), 7);
    chk("t3_idx", int'(winner_idx), 1);
    chk("t3_count", int'(iter_count), 2);
    chk("t3_timeout", int'(timeout), 0);
    chk("t3_pulses", iter_pulses, 2);

    seq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
    run(0, "timeout");
    chk("t4_timeout", int'(timeout), 1);
    chk("t4_count", int'(iter_count), 3);
    chk("t4_onehot", int'(winner_onehot), 0);
    chk("t4_no_winner", int'(no_winner), 0);
    chk("t4_pulses", iter_pulses, 3);
    chk("t4_latency", done_latency(), 9);

    seq = '{4'b0110, 4'b0000};
    run(0, "all_zero");
    chk("t5_count", int'(iter_count), 1);
`ifdef MAXNET_TIE_BREAK_EN
    chk("t5_idx", int'(winner_idx), 1);
    chk("t5_onehot", int'(winner_onehot), 2);
    chk("t5_no_winner", int'(no_winner), 0);
`else
    chk("t5_onehot", int'(winner_onehot), 0);
    chk("t5_no_winner", int'(no_winner), 1);
`endif

    seq = '{4'b0011, 4'b0011, 4'b0011, 4'b1000};
    run(0, "winner_at_budget");
    chk("tb_idx", int'(winner_idx), 3);
    chk("tb_timeout", int'(timeout), 0);
    chk("tb_count", int'(iter_count), 3);

    seq = '{4'b0000};
    run(0, "zero_first");
    chk("tz_no_winner", int'(no_winner), 1);
    chk("tz_onehot", int'(winner_onehot), 0);

    seq = '{4'b1100, 4'b1100, 4'b0100};
    run(1, "restart_ignored");
    chk("t6_idx", int'(winner_idx), 2);
    chk("t6_count", int'(iter_count), 2);
    chk("t6_latency", done_latency(), 7);

    // Abort during the second ITER of a run.
    saved_done = last_done_cyc;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    e_load = 1; e_busy = 1; e_oh = 0; e_idx = 0; e_cnt = 0; e_to = 0; e_nw = 0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1; nz = 4'b1111; e_load = 0; e_iter = 0; e_cnt = 8'(j);
      @(posedge clk); #1; nz = 4'($urandom); e_iter = 1;
    end
    #2;
    chk("pre_abort_count", int'(iter_count), 1);
    e_iter = 0; e_busy = 0; e_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_iter_en", int'(iter_en), 0);
    chk("abort_iter_count", int'(iter_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", last_done_cyc, saved_done);
    $display("abort: reset during ITER, busy=%0d iter_count=%0d", busy, iter_count);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
